// File: rtl/tile_fill_engine.sv
// Rectangle fill/blit engine: CPU programs a rectangle and tile value, the engine
// then streams one tile-memory write per clock to the video block's tile region.
module tile_fill_engine #(
    parameter logic [31:0] TILE_BASE = 32'h0520_0000,
    parameter int          MAP_BITS  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_valid,
    input  logic [3:0]  reg_wstrb,
    input  logic [3:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ready,
    output logic        vid_valid,
    output logic [3:0]  vid_wstrb,
    output logic [31:0] vid_addr,
    output logic [31:0] vid_wdata,
    output logic        busy,
    output logic        done_irq
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int OFF_W = 2 * MAP_BITS + 2;
    localparam logic [MAP_BITS-1:0] ONE = 1;

    logic [1:0]          state;
    logic [MAP_BITS-1:0] x0, y0, wm1, hm1;
    logic [MAP_BITS-1:0] fill_val;
    logic                inc_mode;
    logic                done_flag;
    logic [MAP_BITS-1:0] col, row, val;

    logic                ready;
    logic                acked;
    logic [31:0]         rdata;

    logic                access;
    logic                is_write;
    logic [1:0]          sel;
    logic                engine_busy;
    logic                cfg_we;
    logic                start_req;
    logic                clear_req;
    logic [31:0]         read_val;
    logic [MAP_BITS-1:0] x_sum, y_sum;
    logic [OFF_W-1:0]    tile_off;
    logic                unused_bits;

    // Register handshake: one access per reg_valid assertion; acked holds off a
    // second acknowledge until the requester has dropped reg_valid for a cycle.
    assign access      = reg_valid && !ready && !acked;
    assign is_write    = |reg_wstrb;
    assign sel         = reg_addr[3:2];
    assign engine_busy = (state != ST_IDLE);
    assign cfg_we      = access && is_write && !engine_busy;
    assign start_req   = access && is_write && (sel == 2'd2) && reg_wstrb[0] && reg_wdata[0];
    assign clear_req   = access && is_write && (sel == 2'd2) && reg_wstrb[0] && reg_wdata[1];

    always_comb begin
        read_val = '0;
        case (sel)
            2'd0: begin
                read_val[MAP_BITS-1:0]    = x0;
                read_val[8 +: MAP_BITS]   = y0;
                read_val[16 +: MAP_BITS]  = wm1;
                read_val[24 +: MAP_BITS]  = hm1;
            end
            2'd1: begin
                read_val[MAP_BITS-1:0]    = fill_val;
                read_val[8]               = inc_mode;
            end
            2'd2: begin
                read_val[0]               = engine_busy;
                read_val[1]               = done_flag;
            end
            default: read_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready <= 1'b0;
            acked <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= access;
            acked <= reg_valid && (acked || ready);
            rdata <= access ? read_val : 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x0       <= '0;
            y0       <= '0;
            wm1      <= '0;
            hm1      <= '0;
            fill_val <= '0;
            inc_mode <= 1'b0;
        end else if (cfg_we) begin
            if (sel == 2'd0) begin
                if (reg_wstrb[0]) x0  <= reg_wdata[MAP_BITS-1:0];
                if (reg_wstrb[1]) y0  <= reg_wdata[8 +: MAP_BITS];
                if (reg_wstrb[2]) wm1 <= reg_wdata[16 +: MAP_BITS];
                if (reg_wstrb[3]) hm1 <= reg_wdata[24 +: MAP_BITS];
            end else if (sel == 2'd1) begin
                if (reg_wstrb[0]) fill_val <= reg_wdata[MAP_BITS-1:0];
                if (reg_wstrb[1]) inc_mode <= reg_wdata[8];
            end
        end
    end

    // Completion beats a concurrent CPU clear so a finished fill is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_flag <= 1'b0;
        end else if (state == ST_DONE) begin
            done_flag <= 1'b1;
        end else if (clear_req) begin
            done_flag <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            col   <= '0;
            row   <= '0;
            val   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_req) begin
                        state <= ST_FILL;
                        col   <= '0;
                        row   <= '0;
                        val   <= fill_val;
                    end
                end
                ST_FILL: begin
                    if (col < wm1) begin
                        col <= col + ONE;
                    end else if (row < hm1) begin
                        col <= '0;
                        row <= row + ONE;
                    end else begin
                        state <= ST_DONE;
                    end
                    if (inc_mode) val <= val + ONE;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sums are MAP_BITS wide so a rectangle crossing the map edge wraps to 0.
    assign x_sum    = x0 + col;
    assign y_sum    = y0 + row;
    assign tile_off = {y_sum, x_sum, 2'b00};

    assign vid_valid = (state == ST_FILL);
    assign vid_wstrb = vid_valid ? 4'b0001 : 4'b0000;
    assign vid_addr  = vid_valid ? (TILE_BASE | {{(32-OFF_W){1'b0}}, tile_off}) : 32'h0;
    assign vid_wdata = vid_valid ? {{(32-MAP_BITS){1'b0}}, val} : 32'h0;
    assign busy      = engine_busy;
    assign done_irq  = (state == ST_DONE);
    assign reg_ready = ready;
    assign reg_rdata = rdata;

    assign unused_bits = &{1'b0, reg_addr[1:0], reg_wdata[31:25], reg_wdata[23:17],
                           reg_wdata[15:9], reg_wdata[7:6]};

endmodule

// File: tb/tb_tile_fill_engine.sv
// Directed bench for tile_fill_engine: register access, fill sequences, wrap,
// increment mode, busy protection, done-flag clearing and reset mid-fill.
module tb_tile_fill_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reg_valid = 1'b0;
    logic [3:0]  reg_wstrb = 4'h0;
    logic [3:0]  reg_addr = 4'h0;
    logic [31:0] reg_wdata = 32'h0;
    logic [31:0] reg_rdata;
    logic        reg_ready;
    logic        vid_valid;
    logic [3:0]  vid_wstrb;
    logic [31:0] vid_addr;
    logic [31:0] vid_wdata;
    logic        busy;
    logic        done_irq;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int irq_cnt = 0;
    int irq_cyc = 0;

    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];
    int          wc_q[$];

    tile_fill_engine dut (
        .clk(clk), .reset(reset),
        .reg_valid(reg_valid), .reg_wstrb(reg_wstrb), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ready(reg_ready),
        .vid_valid(vid_valid), .vid_wstrb(vid_wstrb), .vid_addr(vid_addr),
        .vid_wdata(vid_wdata), .busy(busy), .done_irq(done_irq)
    );

    always #5 clk = ~clk;

    // Video-port monitor, sampled on the falling edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (vid_valid) begin
            wa_q.push_back(vid_addr);
            wd_q.push_back(vid_wdata);
            ws_q.push_back(vid_wstrb);
            wc_q.push_back(cyc);
        end
        if (done_irq) begin
            irq_cnt = irq_cnt + 1;
            irq_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic reg_access(input logic [3:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, output logic [31:0] rd, output int ack_cyc);
        int lat;
        lat = 99;
        @(posedge clk); #1;
        reg_valid = 1'b1; reg_addr = addr; reg_wdata = data; reg_wstrb = strb;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (reg_ready) begin
                lat = n;
                break;
            end
        end
        check("reg_ack_latency", 32'(lat), 32'd0);
        rd = reg_rdata;
        ack_cyc = cyc;
        reg_valid = 1'b0;
        reg_wstrb = 4'h0;
    endtask

    task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      output int ack_cyc);
        logic [31:0] dummy;
        reg_access(addr, data, strb, dummy, ack_cyc);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp_v);
        logic [31:0] d;
        int c;
        reg_access(addr, 32'h0, 4'h0, d, c);
        check(tag, d, exp_v);
    endtask

    task automatic clear_log();
        wa_q.delete(); wd_q.delete(); ws_q.delete(); wc_q.delete();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        start = irq_cnt;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk); #1;
            if (irq_cnt != start) break;
        end
        check(tag, 32'(irq_cnt - start), 32'd1);
    endtask

    task automatic check_write(input string tag, input int idx,
                               input logic [31:0] addr, input logic [31:0] data);
        check({tag, "_addr"}, (wa_q.size() > idx) ? wa_q[idx] : 32'hDEAD_BEEF, addr);
        check({tag, "_data"}, (wd_q.size() > idx) ? wd_q[idx] : 32'hDEAD_BEEF, data);
        check({tag, "_strb"}, (ws_q.size() > idx) ? 32'(ws_q[idx]) : 32'hDEAD_BEEF, 32'h1);
    endtask

    // Count, back-to-back spacing, first-write latency and done_irq placement.
    task automatic check_timing(input string tag, input int n, input int ack_cyc);
        int last;
        check({tag, "_count"}, 32'(wc_q.size()), 32'(n));
        if (wc_q.size() > 0) begin
            last = wc_q.size() - 1;
            check({tag, "_first_lat"}, 32'(wc_q[0] - ack_cyc), 32'd1);
            check({tag, "_span"}, 32'(wc_q[last] - wc_q[0]), 32'(n - 1));
            check({tag, "_irq_cyc"}, 32'(irq_cyc - wc_q[last]), 32'd1);
        end
    endtask

    initial begin
        int ac;
        int irq_before;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check("rst_vid_valid", 32'(vid_valid), 32'h0);
        check("rst_vid_addr", vid_addr, 32'h0);
        check("rst_vid_wdata", vid_wdata, 32'h0);
        check("rst_vid_wstrb", 32'(vid_wstrb), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done_irq", 32'(done_irq), 32'h0);
        check("rst_reg_ready", 32'(reg_ready), 32'h0);
        rd_check("rst_rect", 4'h0, 32'h0);
        rd_check("rst_fill", 4'h4, 32'h0);
        rd_check("rst_ctrl", 4'h8, 32'h0);
        rd_check("rst_reg3", 4'hC, 32'h0);

        // Basic 2x2 fill at (3,5), value 7
        wr(4'h0, 32'h0101_0503, 4'hF, ac);
        wr(4'h4, 32'h0000_0007, 4'hF, ac);
        rd_check("basic_rect_rb", 4'h0, 32'h0101_0503);
        clear_log();
        wr(4'h8, 32'h1, 4'h1, ac);
        wait_done("basic_irq", 40);
        check_timing("basic", 4, ac);
        check_write("basic_w0", 0, 32'h0520_050C, 32'd7);
        check_write("basic_w1", 1, 32'h0520_0510, 32'd7);
        check_write("basic_w2", 2, 32'h0520_060C, 32'd7);
        check_write("basic_w3", 3, 32'h0520_0610, 32'd7);
        rd_check("basic_ctrl", 4'h8, 32'h2);

        // Partial strobes: bytes 0/1 only, upper field bits masked on read
        wr(4'h0, 32'hFFFF_FF3F, 4'h3, ac);
        rd_check("strb_rect_rb", 4'h0, 32'h0101_3F3F);
        wr(4'hC, 32'hFFFF_FFFF, 4'hF, ac);
        rd_check("reg3_ignored", 4'hC, 32'h0);

        // Wrap across both map edges from (63,63)
        clear_log();
        wr(4'h8, 32'h1, 4'h1, ac);
        wait_done("wrap_irq", 40);
        check_timing("wrap", 4, ac);
        check_write("wrap_w0", 0, 32'h0520_3FFC, 32'd7);
        check_write("wrap_w1", 1, 32'h0520_3F00, 32'd7);
        check_write("wrap_w2", 2, 32'h0520_00FC, 32'd7);
        check_write("wrap_w3", 3, 32'h0520_0000, 32'd7);

        // Increment mode, 3 wide x 1 high, value 62
        wr(4'h0, 32'h0002_0000, 4'hF, ac);
        wr(4'h4, 32'hFFFF_013E, 4'hF, ac);
        rd_check("inc_fill_rb", 4'h4, 32'h0000_013E);
        clear_log();
        wr(4'h8, 32'h1, 4'h1, ac);
        wait_done("inc_irq", 40);
        check_timing("inc", 3, ac);
        check_write("inc_w0", 0, 32'h0520_0000, 32'd62);
        check_write("inc_w1", 1, 32'h0520_0004, 32'd63);
        check_write("inc_w2", 2, 32'h0520_0008, 32'd0);

        // Busy protection on a full 64x64 fill
        wr(4'h0, 32'h3F3F_0000, 4'hF, ac);
        wr(4'h4, 32'h0000_0005, 4'hF, ac);
        clear_log();
        irq_before = irq_cnt;
        wr(4'h8, 32'h1, 4'h1, ac);
        wr(4'h8, 32'h2, 4'h1, ac);
        rd_check("busy_ctrl_cleared", 4'h8, 32'h1);
        wr(4'h0, 32'h0, 4'hF, ac);
        wr(4'h4, 32'h0000_0011, 4'hF, ac);
        wr(4'h8, 32'h1, 4'h1, ac);
        rd_check("busy_rect_kept", 4'h0, 32'h3F3F_0000);
        rd_check("busy_fill_kept", 4'h4, 32'h0000_0005);
        wait_done("busy_irq", 5000);
        repeat (10) @(negedge clk);
        check("busy_irq_total", 32'(irq_cnt - irq_before), 32'd1);
        check("busy_count", 32'(wc_q.size()), 32'd4096);
        if (wc_q.size() == 4096) begin
            check("busy_span", 32'(wc_q[4095] - wc_q[0]), 32'd4095);
            check_write("busy_first", 0, 32'h0520_0000, 32'd5);
            check_write("busy_second", 1, 32'h0520_0004, 32'd5);
            check_write("busy_row1", 64, 32'h0520_0100, 32'd5);
            check_write("busy_last", 4095, 32'h0520_3FFC, 32'd5);
        end
        rd_check("busy_ctrl_after", 4'h8, 32'h2);

        // Done clear while idle
        wr(4'h8, 32'h2, 4'h1, ac);
        rd_check("clr_ctrl", 4'h8, 32'h0);

        // Clear accepted on the same edge that ends DONE: the set must win
        wr(4'h0, 32'h0, 4'hF, ac);
        clear_log();
        irq_before = irq_cnt;
        wr(4'h8, 32'h1, 4'h1, ac);
        @(posedge clk); #1;
        reg_valid = 1'b1; reg_addr = 4'h8; reg_wdata = 32'h2; reg_wstrb = 4'h1;
        check("race_done_state", 32'(done_irq), 32'h1);
        @(posedge clk); #1;
        check("race_clear_acked", 32'(reg_ready), 32'h1);
        reg_valid = 1'b0; reg_wstrb = 4'h0;
        check("race_irq", 32'(irq_cnt - irq_before), 32'd1);
        check("race_count", 32'(wc_q.size()), 32'd1);
        rd_check("race_ctrl", 4'h8, 32'h2);

        // Reset during write 10 of a 4x4 fill
        wr(4'h0, 32'h0303_0000, 4'hF, ac);
        wr(4'h4, 32'h0000_0001, 4'hF, ac);
        clear_log();
        irq_before = irq_cnt;
        wr(4'h8, 32'h1, 4'h1, ac);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk); #1;
            if (wa_q.size() >= 10) break;
        end
        check("rstmid_reached_w10", 32'(wa_q.size()), 32'd10);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("rstmid_vid_valid", 32'(vid_valid), 32'h0);
        check("rstmid_busy", 32'(busy), 32'h0);
        repeat (20) @(negedge clk);
        #1;
        check("rstmid_no_more_writes", 32'(wa_q.size()), 32'd10);
        check("rstmid_no_irq", 32'(irq_cnt - irq_before), 32'd0);
        rd_check("rstmid_rect", 4'h0, 32'h0);
        rd_check("rstmid_fill", 4'h4, 32'h0);
        rd_check("rstmid_ctrl", 4'h8, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
